// File: rtl/mips_pkg.sv
// Shared MIPS core constants; data-memory geometry is derived here so the
// memory, its bus interface and any users agree on the same widths.
package mips_pkg;

  localparam int unsigned DM_ADDR_W = 10;
  localparam int unsigned DM_DATA_W = 32;
  localparam int unsigned DM_IDX_W  = DM_ADDR_W - 2;
  localparam int unsigned DM_DEPTH  = 2 ** DM_IDX_W;

endpackage

// File: rtl/data_mem_4k_if.sv
// Data-memory bus: the core (master) drives a byte address, a pre-merged word and
// a write enable, and receives the addressed word combinationally.
interface data_mem_4k_if
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W = DM_ADDR_W,
  parameter int unsigned DATA_W = DM_DATA_W
);

  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic              we;
  logic [DATA_W-1:0] dout;

  modport master (
    output addr,
    output din,
    output we,
    input  dout
  );

  modport slave (
    input  addr,
    input  din,
    input  we,
    output dout
  );

endinterface

// File: rtl/data_mem_4k.sv
// Word-organised data memory: asynchronous read, synchronous write, synchronous clear.
// Define DM_TRACE_EN to print one simulation line per committed write and per reset.
module data_mem_4k
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W = DM_ADDR_W,
  parameter int unsigned DATA_W = DM_DATA_W
) (
  input  logic          clk,
  input  logic          rst,
  data_mem_4k_if.slave  bus
);

  localparam int unsigned IDX_W = ADDR_W - 2;
  localparam int unsigned DEPTH = 2 ** IDX_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  idx;
  logic              unused_addr_lo;

  // Byte offset is irrelevant: the caller merges sub-word data before writing.
  assign idx            = bus.addr[ADDR_W-1:2];
  assign unused_addr_lo = ^bus.addr[1:0];

  // Reset wins over write; a write issued in the reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[IDX_W'(i)] <= '0;
      end
`ifdef DM_TRACE_EN
      $display("t=%0d dm reset", $time);
`else
`endif
    end else if (bus.we) begin
      mem[idx] <= bus.din;
`ifdef DM_TRACE_EN
      $display("t=%0d dm write addr=0x%0x idx=%0d data=0x%0x", $time, bus.addr, idx, bus.din);
`else
`endif
    end
  end

  // No write-through: the old word stays visible until the write edge.
  assign bus.dout = mem[idx];

endmodule

// File: tb/tb_data_mem_4k.sv
// Self-checking bench for data_mem_4k: directed scenarios followed by random
// read/write/reset traffic compared against a word-array reference model.
module tb_data_mem_4k;

  logic clk;
  logic rst;

  data_mem_4k_if bus ();

  data_mem_4k dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] ref_mem [256];
  int checks = 0;
  int errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [9:0] a);
    return ref_mem[int'(a) / 4];
  endfunction

  // Advance one rising edge, applying the reference rules, then return at the falling edge.
  task automatic edge_step();
    @(posedge clk);
    if (rst === 1'b1) begin
      for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
    end else if (bus.we === 1'b1) begin
      ref_mem[int'(bus.addr) / 4] = bus.din;
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic r, input logic w, input logic [9:0] a, input logic [31:0] d);
    rst      = r;
    bus.we   = w;
    bus.addr = a;
    bus.din  = d;
    #1;
  endtask

  initial begin
    logic [9:0]  a;
    logic [31:0] d;
    logic        w;
    logic        r;

    for (int i = 0; i < 256; i++) ref_mem[i] = 'x;
    drive(1'b1, 1'b0, 10'h000, 32'h0);
    @(negedge clk);

    // 1: reset clears the whole array
    edge_step();
    drive(1'b0, 1'b0, 10'h000, 32'h0);
    check("reset_word0", bus.dout, 32'h0000_0000);
    drive(1'b0, 1'b0, 10'h3FC, 32'h0);
    check("reset_word255", bus.dout, 32'h0000_0000);

    // 2: write visible only after the edge
    drive(1'b0, 1'b1, 10'h004, 32'hDEAD_BEEF);
    check("write_before_edge", bus.dout, 32'h0000_0000);
    edge_step();
    drive(1'b0, 1'b0, 10'h004, 32'h0);
    check("write_after_edge", bus.dout, 32'hDEAD_BEEF);

    // 3: byte offset ignored on read and on write
    drive(1'b0, 1'b0, 10'h005, 32'h0);
    check("read_off1", bus.dout, 32'hDEAD_BEEF);
    drive(1'b0, 1'b0, 10'h006, 32'h0);
    check("read_off2", bus.dout, 32'hDEAD_BEEF);
    drive(1'b0, 1'b0, 10'h007, 32'h0);
    check("read_off3", bus.dout, 32'hDEAD_BEEF);
    drive(1'b0, 1'b1, 10'h00B, 32'h1122_3344);
    edge_step();
    drive(1'b0, 1'b0, 10'h008, 32'h0);
    check("write_off3_word2", bus.dout, 32'h1122_3344);
    drive(1'b0, 1'b0, 10'h004, 32'h0);
    check("write_off3_word1_kept", bus.dout, 32'hDEAD_BEEF);

    // 4: din ignored while we=0
    drive(1'b0, 1'b0, 10'h004, 32'hFFFF_FFFF);
    for (int k = 0; k < 3; k++) begin
      edge_step();
      check("we0_hold", bus.dout, 32'hDEAD_BEEF);
    end

    // 5: reset has priority over a simultaneous write
    drive(1'b1, 1'b1, 10'h008, 32'hA5A5_A5A5);
    edge_step();
    drive(1'b0, 1'b0, 10'h008, 32'h0);
    check("rst_over_we_word2", bus.dout, 32'h0000_0000);
    drive(1'b0, 1'b0, 10'h004, 32'h0);
    check("rst_over_we_word1", bus.dout, 32'h0000_0000);

    // 6: top word
    drive(1'b0, 1'b1, 10'h3FC, 32'hCAFE_F00D);
    edge_step();
    drive(1'b0, 1'b0, 10'h3FC, 32'h0);
    check("top_word", bus.dout, 32'hCAFE_F00D);
    drive(1'b0, 1'b0, 10'h000, 32'h0);
    check("top_word_word0_kept", bus.dout, 32'h0000_0000);

    // Random traffic against the reference array
    for (int n = 0; n < 300; n++) begin
      a = 10'($urandom);
      d = $urandom;
      w = ($urandom_range(0, 1) == 1);
      r = ($urandom_range(0, 39) == 0);
      drive(r, w, a, d);
      check("rand_pre_edge", bus.dout, model_read(a));
      edge_step();
      check("rand_post_edge", bus.dout, model_read(a));
      a = 10'($urandom);
      drive(1'b0, 1'b0, a, 32'($urandom));
      check("rand_read", bus.dout, model_read(a));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
